// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: drives the 12-vector unlock sequence onto a detector's
// i1..i4 inputs, holding each vector HOLD_CYCLES clocks, with a
// start/busy/done/aborted handshake.
// Optional feature macro FSM_SEQ_DRIVER_CORRUPT_EN adds corrupt/corrupt_step
// inputs that bit-invert one chosen vector of the sequence.
module fsm_seq_driver #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
`ifdef FSM_SEQ_DRIVER_CORRUPT_EN
  input  logic       corrupt,
  input  logic [3:0] corrupt_step,
`endif
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       i4,
  output logic       busy,
  output logic [3:0] step,
  output logic       done,
  output logic       aborted
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned STEP_W    = 4;
  localparam int unsigned VEC_W     = 4;
  localparam int unsigned NUM_STEPS = 12;

  // A hold of 0 behaves like a hold of 1.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  hold_cnt;
  logic [VEC_W-1:0]  vec;
  logic              corrupt_q;
  logic [STEP_W-1:0] corrupt_step_q;
  logic              corrupt_in;
  logic [STEP_W-1:0] corrupt_step_in;

`ifdef FSM_SEQ_DRIVER_CORRUPT_EN
  assign corrupt_in      = corrupt;
  assign corrupt_step_in = corrupt_step;
`else
  assign corrupt_in      = 1'b0;
  assign corrupt_step_in = '0;
`endif

  // Unlock sequence, returned as {i4,i3,i2,i1}; don't-cares are 0.
  function automatic logic [VEC_W-1:0] table_vec(input logic [STEP_W-1:0] s);
    case (s)
      4'd1:    table_vec = 4'b0100;
      4'd2:    table_vec = 4'b1001;
      4'd3:    table_vec = 4'b0000;
      4'd4:    table_vec = 4'b0100;
      4'd5:    table_vec = 4'b0010;
      4'd6:    table_vec = 4'b0001;
      4'd7:    table_vec = 4'b1000;
      4'd8:    table_vec = 4'b0000;
      4'd9:    table_vec = 4'b1000;
      4'd10:   table_vec = 4'b0100;
      4'd11:   table_vec = 4'b0001;
      default: table_vec = 4'b0000;
    endcase
  endfunction

  // Table vector, inverted when it is the selected corrupt step.
  // Out-of-range corrupt steps never match a driven step, so they are inert.
  function automatic logic [VEC_W-1:0] drive_vec(input logic [STEP_W-1:0] s,
                                                 input logic c,
                                                 input logic [STEP_W-1:0] cs);
    drive_vec = table_vec(s) ^ ((c && (cs == s)) ? 4'hF : 4'h0);
  endfunction

  assign i1 = vec[0];
  assign i2 = vec[1];
  assign i3 = vec[2];
  assign i4 = vec[3];

  // Sequencer FSM; every output is computed alongside the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      vec            <= '0;
      busy           <= 1'b0;
      step           <= '0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      corrupt_q      <= 1'b0;
      corrupt_step_q <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        // The done-pulse cycle samples start like IDLE so back-to-back
        // sequences are separated by exactly one cycle.
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state          <= S_DRIVE;
            hold_cnt       <= '0;
            step           <= STEP_W'(1);
            busy           <= 1'b1;
            corrupt_q      <= corrupt_in;
            corrupt_step_q <= corrupt_step_in;
            vec            <= drive_vec(STEP_W'(1), corrupt_in, corrupt_step_in);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            step  <= '0;
            vec   <= '0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state    <= S_IDLE;
            aborted  <= 1'b1;
            busy     <= 1'b0;
            step     <= '0;
            vec      <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (step == STEP_W'(NUM_STEPS)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              step  <= '0;
              vec   <= '0;
            end else begin
              step <= step + STEP_W'(1);
              vec  <= drive_vec(step + STEP_W'(1), corrupt_q, corrupt_step_q);
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          step     <= '0;
          vec      <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
